// File: rtl/axi_ctrl_bank_if.sv
// AXI4-lite bus bundle for the control register bank.
// The slave modport is the register bank; the master modport is the PS-side driver.
interface axi_ctrl_bank_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic                      rvalid;
    logic                      rready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_ctrl_bank.sv
// AXI4-lite control/status register bank for C_NUM_CH processing channels.
// Per-channel config, start pulse and busy/done tracking live in axi_ctrl_bank_ch;
// the top handles bus handshakes, address decode, IRQ enable and readback.

// One channel: len/gain config, start pulse, busy, done edge and sticky IRQ bit.
module axi_ctrl_bank_ch #(
    parameter int C_LEN_W  = 10,
    parameter int C_GAIN_W = 8
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                wr_ctrl,
    input  logic                wr_gain,
    input  logic                go,
    input  logic                clr_stat,
    input  logic [C_LEN_W-1:0]  len_d,
    input  logic [C_LEN_W-1:0]  len_m,
    input  logic [C_GAIN_W-1:0] gain_d,
    input  logic [C_GAIN_W-1:0] gain_m,
    input  logic                done,
    output logic [C_LEN_W-1:0]  len,
    output logic [C_GAIN_W-1:0] gain,
    output logic                start,
    output logic                busy,
    output logic                done_lvl,
    output logic                stat
);
    logic rise;
    logic start_req;

    assign rise      = done & ~done_lvl;
    assign start_req = wr_ctrl & go;

    // Config, start pulse and status; a start request while busy only updates len,
    // and a start colliding with a done edge leaves the channel busy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            len      <= '0;
            gain     <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            done_lvl <= 1'b0;
            stat     <= 1'b0;
        end else begin
            done_lvl <= done;
            start    <= start_req & ~busy;
            busy     <= start_req | (busy & ~rise);
            stat     <= (stat & ~clr_stat) | rise;
            if (wr_ctrl) len  <= (len & ~len_m) | (len_d & len_m);
            if (wr_gain) gain <= (gain & ~gain_m) | (gain_d & gain_m);
        end
    end
endmodule

module axi_ctrl_bank #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_CH     = 4,
    parameter int C_LEN_W      = 10,
    parameter int C_GAIN_W     = 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi_ctrl_bank_if.slave               s_axi,
    output logic [C_NUM_CH*C_LEN_W-1:0]  num_of_inp,
    output logic [C_NUM_CH*C_GAIN_W-1:0] gain,
    output logic [C_NUM_CH-1:0]          start,
    input  logic [C_NUM_CH-1:0]          done,
    output logic                         irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        R_INFO, R_IRQ_EN, R_IRQ_STAT, R_CTRL, R_GAIN, R_STATUS, R_NONE
    } reg_e;

    typedef struct packed {
        reg_e       kind;
        logic [2:0] ch;
    } dec_t;

    // Word-granular decode of the low address byte; slot 0 is global, slot k+1 is channel k.
    function automatic dec_t decode(input logic [7:0] off);
        dec_t       d;
        logic [3:0] slot;
        d.kind = R_NONE;
        d.ch   = '0;
        slot   = off[7:4];
        if (slot == 4'd0) begin
            case (off[3:2])
                2'd0:    d.kind = R_INFO;
                2'd1:    d.kind = R_IRQ_EN;
                2'd2:    d.kind = R_IRQ_STAT;
                default: d.kind = R_NONE;
            endcase
        end else if (int'(slot) <= C_NUM_CH) begin
            d.ch = 3'(slot - 4'd1);
            case (off[3:2])
                2'd0:    d.kind = R_CTRL;
                2'd1:    d.kind = R_GAIN;
                2'd2:    d.kind = R_STATUS;
                default: d.kind = R_NONE;
            endcase
        end
        return d;
    endfunction

    // Write-side holding registers
    logic        aw_held, w_held, bvalid_q, commit;
    logic [1:0]  bresp_q;
    logic [7:0]  aw_off;
    logic [31:0] wd_q, wmask;
    logic [3:0]  ws_q;
    dec_t        wdec, rdec;

    // Read-side registers
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q, rval;

    // Global IRQ state and per-channel views
    logic [C_NUM_CH-1:0]               irq_en, stat, busy, done_lvl, start_q;
    logic                              irq_gen;
    logic [C_NUM_CH-1:0][C_LEN_W-1:0]  len_q;
    logic [C_NUM_CH-1:0][C_GAIN_W-1:0] gain_q;

    assign commit = aw_held & w_held;
    assign wdec   = decode(aw_off);
    assign rdec   = decode(s_axi.araddr[7:0]);

    for (genvar b = 0; b < 4; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{ws_q[b]}};
    end

    assign s_axi.awready = !areset && !aw_held && !bvalid_q;
    assign s_axi.wready  = !areset && !w_held  && !bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = !areset && !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign num_of_inp = len_q;
    assign gain       = gain_q;
    assign start      = start_q;

    // AW and W are captured independently; both held commits on the next edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_off   <= '0;
            wd_q     <= '0;
            ws_q     <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (s_axi.awvalid && s_axi.awready) begin
                aw_held <= 1'b1;
                aw_off  <= s_axi.awaddr[7:0];
            end
            if (s_axi.wvalid && s_axi.wready) begin
                w_held <= 1'b1;
                wd_q   <= s_axi.wdata;
                ws_q   <= s_axi.wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (wdec.kind == R_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // IRQ enable register and the registered level interrupt.
    always_ff @(posedge aclk) begin
        if (areset) begin
            irq_en  <= '0;
            irq_gen <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (commit && wdec.kind == R_IRQ_EN) begin
                irq_en <= (irq_en & ~wmask[C_NUM_CH-1:0]) | (wd_q[C_NUM_CH-1:0] & wmask[C_NUM_CH-1:0]);
                if (ws_q[3]) irq_gen <= wd_q[31];
            end
            irq <= irq_gen & |(irq_en & stat);
        end
    end

    for (genvar k = 0; k < C_NUM_CH; k++) begin : g_ch
        axi_ctrl_bank_ch #(
            .C_LEN_W  (C_LEN_W),
            .C_GAIN_W (C_GAIN_W)
        ) u_ch (
            .aclk     (aclk),
            .areset   (areset),
            .wr_ctrl  (commit && wdec.kind == R_CTRL && wdec.ch == 3'(k)),
            .wr_gain  (commit && wdec.kind == R_GAIN && wdec.ch == 3'(k)),
            .go       (wd_q[24] & ws_q[3]),
            .clr_stat (commit && wdec.kind == R_IRQ_STAT && wd_q[k] && ws_q[0]),
            .len_d    (wd_q[C_LEN_W-1:0]),
            .len_m    (wmask[C_LEN_W-1:0]),
            .gain_d   (wd_q[C_GAIN_W-1:0]),
            .gain_m   (wmask[C_GAIN_W-1:0]),
            .done     (done[k]),
            .len      (len_q[k]),
            .gain     (gain_q[k]),
            .start    (start_q[k]),
            .busy     (busy[k]),
            .done_lvl (done_lvl[k]),
            .stat     (stat[k])
        );
    end

    // Readback mux from current register state; reserved bits stay 0.
    always_comb begin
        rval = '0;
        case (rdec.kind)
            R_INFO:     rval = {16'd0, 8'h02, 8'(C_NUM_CH)};
            R_IRQ_EN:   begin
                rval[C_NUM_CH-1:0] = irq_en;
                rval[31]           = irq_gen;
            end
            R_IRQ_STAT: rval[C_NUM_CH-1:0] = stat;
            default: begin
                for (int k = 0; k < C_NUM_CH; k++) begin
                    if (rdec.ch == 3'(k)) begin
                        if (rdec.kind == R_CTRL) begin
                            rval[C_LEN_W-1:0] = len_q[k];
                            rval[24]          = busy[k];
                        end else if (rdec.kind == R_GAIN) begin
                            rval[C_GAIN_W-1:0] = gain_q[k];
                        end else if (rdec.kind == R_STATUS) begin
                            rval[1:0] = {busy[k], done_lvl[k]};
                        end
                    end
                end
            end
        endcase
    end

    // Read data latches on the AR handshake edge and holds until rready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (s_axi.arvalid && s_axi.arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rval;
            rresp_q  <= (rdec.kind == R_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule
